// File: rtl/idma_read_ibuffer_pkg.sv
// Shared iDMA definitions: width defaults and
// state encoding for the ibuffer read path.
package idma_read_ibuffer_pkg;

  localparam int IDMA_DATA_WIDTH = 128;
  localparam int IDMA_MEM_AW     = 15;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    READ  = ST_READ,
    DRAIN = ST_DRAIN
  } rd_state_e;

endpackage

// File: rtl/idma_rd_fifo.sv
// Small synchronous FIFO that absorbs SRAM read
// returns; the caller's credit logic prevents overflow.
module idma_rd_fifo #(
  parameter int  DEPTH = 4,
  parameter int  WIDTH = 128,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;

  // storage write; contents need no reset
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din;
  end

  // pointer and occupancy tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rptr];
  assign empty = (count == '0);

endmodule

// File: rtl/idma_read_ibuffer.sv
// Drains a contiguous ibuffer region onto the DMA
// write-data stream with credit-based read issue.
module idma_read_ibuffer
  import idma_read_ibuffer_pkg::*;
#(
  parameter int DATA_WIDTH = IDMA_DATA_WIDTH,
  parameter int MEM_AW     = IDMA_MEM_AW,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dma_wr_req,
  input  logic [MEM_AW-1:0]     dma_wr_base_addr,
  input  logic [MEM_AW-1:0]     dma_wr_data_num,
  output logic                  busy,
  output logic                  ibuffer_cen,
  output logic                  ibuffer_wen,
  input  logic                  ibuffer_ready,
  output logic [MEM_AW-1:0]     ibuffer_addr,
  input  logic [DATA_WIDTH-1:0] ibuffer_rdata,
  output logic                  dma_wr_data_valid,
  output logic [DATA_WIDTH-1:0] dma_wr_data,
  output logic [STRB_WIDTH-1:0] dma_wr_strb,
  input  logic                  dma_wr_data_ready,
  output logic                  dma_read_done
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  rd_state_e         state;
  logic [MEM_AW-1:0] addr_q;
  logic [MEM_AW-1:0] num_q;
  logic [MEM_AW-1:0] rd_cnt;
  logic [MEM_AW-1:0] wr_cnt;
  logic              inflight;
  logic [CW-1:0]     fifo_count;
  logic              fifo_empty;
  logic              credit_ok;
  logic              rd_acc;
  logic              pop;
  logic              last_rd;
  logic              last_wr;

  // a read in flight already owns a FIFO slot
  assign credit_ok = (fifo_count + CW'(inflight))
                     < CW'(FIFO_DEPTH);

  assign ibuffer_cen  = (state == READ) && credit_ok;
  assign ibuffer_wen  = 1'b0;
  assign ibuffer_addr = addr_q + rd_cnt;
  assign rd_acc       = ibuffer_cen && ibuffer_ready;

  assign last_rd = (rd_cnt == num_q - MEM_AW'(1));
  assign last_wr = (wr_cnt == num_q - MEM_AW'(1));

  assign dma_wr_data_valid = !fifo_empty;
  assign dma_wr_strb       = '1;
  assign pop           = dma_wr_data_valid && dma_wr_data_ready;
  assign dma_read_done = (state == DRAIN) && pop && last_wr;
  assign busy          = (state != IDLE);

  // transfer FSM, issue/output counters, read-latency flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      addr_q   <= '0;
      num_q    <= '0;
      rd_cnt   <= '0;
      wr_cnt   <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= rd_acc;
      if (rd_acc) rd_cnt <= rd_cnt + MEM_AW'(1);
      if (pop)    wr_cnt <= wr_cnt + MEM_AW'(1);
      case (state)
        IDLE: begin
          if (dma_wr_req && (dma_wr_data_num != '0)) begin
            addr_q <= dma_wr_base_addr;
            num_q  <= dma_wr_data_num;
            rd_cnt <= '0;
            wr_cnt <= '0;
            state  <= READ;
          end
        end
        READ: begin
          if (rd_acc && last_rd) state <= DRAIN;
        end
        DRAIN: begin
          if (dma_read_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  idma_rd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight),
    .din   (ibuffer_rdata),
    .pop   (pop),
    .dout  (dma_wr_data),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: doc/idma_read_ibuffer.md
Name: idma_read_ibuffer

Overview:
- Reverse-direction companion to the iDMA ibuffer write path: drains a contiguous region of the ibuffer SRAM and streams it out on the DMA write-data channel toward the NoC/AXI side.
- Issues SRAM reads with `ibuffer_ready` back-pressure and absorbs the fixed 1-cycle SRAM read latency in a small credit-managed FIFO, so the output stream tolerates arbitrary `dma_wr_data_ready` stalls without losing or duplicating beats.
- Pulses a done flag when the last beat leaves.

Parameters:
- DATA_WIDTH, 128, width of SRAM word and DMA data beat
- MEM_AW, 15, ibuffer word-address width; also the width of the beat count
- STRB_WIDTH, DATA_WIDTH/8, byte-strobe width
- FIFO_DEPTH, 4, output FIFO entries; power of two, minimum 4

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- dma_wr_req  input  1  start pulse; sampled only when idle
- dma_wr_base_addr  input  MEM_AW  first ibuffer word address; sampled with dma_wr_req
- dma_wr_data_num  input  MEM_AW  beats to transfer; sampled with dma_wr_req
- busy  output  1  transfer in progress
- ibuffer_cen  output  1  SRAM access request (valid)
- ibuffer_wen  output  1  write enable, constant 0 (read)
- ibuffer_ready  input  1  SRAM accepts the request this cycle
- ibuffer_addr  output  MEM_AW  read address
- ibuffer_rdata  input  DATA_WIDTH  read data, valid exactly 1 cycle after an accepted read
- dma_wr_data_valid  output  1  output beat valid
- dma_wr_data  output  DATA_WIDTH  output beat
- dma_wr_strb  output  STRB_WIDTH  constant all-ones
- dma_wr_data_ready  input  1  downstream accepts beat
- dma_read_done  output  1  single-cycle pulse on last output handshake

Behaviour:
- Reset (`rst` high at a clk edge) applies regardless of state:
  - state=IDLE; all counters and FIFO pointers cleared; in-flight read flag cleared.
  - Outputs: busy=0, ibuffer_cen=0, ibuffer_addr=0, dma_wr_data_valid=0, dma_read_done=0.
  - A reset mid-transfer discards in-flight and buffered data. rdata returning in the cycle after reset is ignored.
- FSM: IDLE, READ, DRAIN.
  - IDLE→READ: dma_wr_req=1 and dma_wr_data_num!=0.
    - Latch base into addr_q, num into num_q.
    - Clear issue counter rd_cnt and output counter wr_cnt.
    - busy=1 from the next cycle.
  - IDLE with dma_wr_req=1 and num==0: request ignored; no done pulse.
  - dma_wr_req while busy: ignored, with no side effects.
  - READ→DRAIN: in the cycle the read with rd_cnt==num_q-1 is accepted.
  - DRAIN→IDLE: in the cycle the output handshake with wr_cnt==num_q-1 occurs. dma_read_done=1 in that same cycle; busy=0 in the next cycle. A new dma_wr_req is accepted from the cycle after done.
- Read issue:
  - ibuffer_cen = (state==READ) && credit_ok.
  - credit_ok = (fifo_count + inflight) < FIFO_DEPTH.
  - ibuffer_addr = addr_q + rd_cnt, mod 2^MEM_AW (wraps silently).
  - Read accepted when ibuffer_cen && ibuffer_ready; rd_cnt increments on acceptance.
  - cen/addr are held stable while ready=0.
- Read return:
  - inflight is a 1-bit register set on the accepted read and cleared the next cycle unless another read is accepted.
  - When inflight=1, ibuffer_rdata is pushed into the FIFO unconditionally. Credit guarantees space.
- Output:
  - dma_wr_data_valid = fifo not empty; dma_wr_data = FIFO head (registered storage).
  - Pop on valid && ready; wr_cnt increments on pop.
  - Simultaneous push and pop in one cycle: count unchanged.
- Latency:
  - Read accepted in cycle T → beat valid at the output in T+2.
  - First read issues in the cycle after dma_wr_req. First valid beat at the earliest 3 cycles after the req cycle.
  - With ready held high on both sides: 1 beat/cycle sustained, with no bubbles.
- Counter widths are MEM_AW. num_q=0 never enters READ; a maximum num_q of 2^MEM_AW-1 is supported.

Decomposition:
- Shared iDMA package holds:
  - FSM state encoding localparams (IDLE=2'd0, READ=2'd1, DRAIN=2'd2).
  - Common iDMA width defaults (DATA_WIDTH, MEM_AW).
- One sub-module, idma_rd_fifo:
  - Synchronous FIFO with DEPTH and WIDTH parameters, push/pop/empty/count, synchronous active-high reset.
  - No overflow protection, since the credit logic guarantees none.

Test Plan:
- Single-beat transfer: base=0x0010, num=1, both readies held at 1 → one read at addr 0x0010; beat valid 2 cycles later; dma_read_done pulses with that handshake; busy returns to 0 the next cycle.
- Streaming: base=0x0100, num=16, ready=1 on both sides → addresses 0x0100..0x010F on consecutive cycles; 16 back-to-back output beats matching SRAM contents; exactly one done pulse.
- Output back-pressure: num=32, dma_wr_data_ready toggles randomly at 30% duty → ibuffer_cen is deasserted whenever count+inflight reaches 4; no beat is lost or duplicated; output order equals address order.
- SRAM back-pressure: ibuffer_ready=0 for 5 cycles mid-transfer → cen and addr stay stable throughout; the transfer completes with correct data.
- Wrap and ignore: base=0x7FFE with MEM_AW=15, num=4 → addresses 0x7FFE, 0x7FFF, 0x0000, 0x0001. A dma_wr_req asserted mid-transfer is ignored. A request with num=0 produces no reads and no done pulse.
- Reset mid-transfer: rst asserted after 3 of 10 beats → all outputs are at reset values the next cycle; a new request with num=2 completes cleanly with no stale data.
